// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix stream loader.
// Holds the element width default, the load FSM states and index-width sizing.
package matrix_pkg;

    localparam int DATA_W_DFLT = 8;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        FULL
    } state_t;

    // Index counters need at least one bit, even when N=1.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker over an N x N matrix in row-major order; flags the last cell.
// Latency: indices registered, last_o decoded from registers; no backpressure (en_i gates stepping).
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + IDX_W'(1);
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == LAST_IDX) && (col_q == LAST_IDX);

endmodule

// File: rtl/matrix_stream_loader.sv
// Collects a row-major byte stream (A then B) into two N x N register arrays for the adder stage.
// Latency: mat_valid rises right after the 2*N*N-th transfer edge; in_ready is low only while FULL.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_W-1:0]                mat_a [N][N],
    output logic [DATA_W-1:0]                mat_b [N][N],
    output logic                             mat_valid,
    input  logic                             mat_ready,
    output logic [$clog2(2*N*N+1)-1:0]       load_cnt
);

    localparam int IDX_W = clog2_min1(N);
    localparam int CNT_W = $clog2(2*N*N+1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic [DATA_W-1:0]  mat_a_q [N][N];
    logic [DATA_W-1:0]  mat_b_q [N][N];

    logic               accept;
    logic               last_cell;
    logic [IDX_W-1:0]   row;
    logic [IDX_W-1:0]   col;

    assign in_ready  = (state_q != FULL);
    assign mat_valid = (state_q == FULL);
    // A flush drops any element offered in the same cycle.
    assign accept    = in_valid && in_ready && !flush;

    matrix_index_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (accept),
        .clr_i  (flush),
        .row_o  (row),
        .col_o  (col),
        .last_o (last_cell)
    );

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        if (flush) begin
            state_d    = LOAD_A;
            load_cnt_d = '0;
        end else begin
            case (state_q)
                LOAD_A: if (accept && last_cell) state_d = LOAD_B;
                LOAD_B: if (accept && last_cell) state_d = FULL;
                FULL: begin
                    if (mat_ready) begin
                        state_d    = LOAD_A;
                        load_cnt_d = '0;
                    end
                end
                default: state_d = LOAD_A;
            endcase
            if (accept) load_cnt_d = load_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    // Matrix contents survive accept and flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mat_a_q[r][c] <= '0;
                    mat_b_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            if (state_q == LOAD_A) mat_a_q[row][col] <= in_data;
            if (state_q == LOAD_B) mat_b_q[row][col] <= in_data;
        end
    end

    assign mat_a    = mat_a_q;
    assign mat_b    = mat_b_q;
    assign load_cnt = load_cnt_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed and randomized stimulus against a position-based reference model of the loader.
module tb_matrix_stream_loader;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mat_a [3][3];
    logic [7:0] mat_b [3][3];
    logic       mat_valid;
    logic       mat_ready;
    logic [4:0] load_cnt;

    logic       flush1;
    logic [7:0] in_data1;
    logic       in_valid1;
    logic       in_ready1;
    logic [7:0] mat_a1 [1][1];
    logic [7:0] mat_b1 [1][1];
    logic       mat_valid1;
    logic       mat_ready1;
    logic [1:0] load_cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model: element k of a load lands at A[k/3][k%3] for k<9, else B.
    logic [7:0] exp_a [3][3];
    logic [7:0] exp_b [3][3];
    int         m_cnt;
    bit         m_full;

    matrix_stream_loader #(.N(3), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .load_cnt  (load_cnt)
    );

    matrix_stream_loader #(.N(1), .DATA_W(8)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush1),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .mat_a     (mat_a1),
        .mat_b     (mat_b1),
        .mat_valid (mat_valid1),
        .mat_ready (mat_ready1),
        .load_cnt  (load_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pack3(input logic [7:0] m [3][3]);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                r[(i*3+j)*8 +: 8] = m[i][j];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                exp_a[i][j] = 8'h00;
                exp_b[i][j] = 8'h00;
            end
        m_cnt  = 0;
        m_full = 1'b0;
    endtask

    task automatic check_all();
        chk("in_ready",  {71'd0, in_ready},  {71'd0, !m_full});
        chk("mat_valid", {71'd0, mat_valid}, {71'd0, m_full});
        chk("load_cnt",  {67'd0, load_cnt},  72'(m_cnt));
        chk("mat_a",     pack3(mat_a),       pack3(exp_a));
        chk("mat_b",     pack3(mat_b),       pack3(exp_b));
    endtask

    // One clock: model decides from the inputs held across the edge.
    task automatic step();
        bit         xfer;
        bit         fl;
        bit         rdy;
        logic [7:0] v;
        xfer = in_valid && !m_full;
        fl   = flush;
        rdy  = mat_ready;
        v    = in_data;
        @(posedge clk);
        #1;
        if (fl) begin
            m_cnt  = 0;
            m_full = 1'b0;
        end else if (m_full) begin
            if (rdy) begin
                m_full = 1'b0;
                m_cnt  = 0;
            end
        end else if (xfer) begin
            if (m_cnt < 9) exp_a[m_cnt/3][m_cnt%3] = v;
            else           exp_b[(m_cnt-9)/3][(m_cnt-9)%3] = v;
            m_cnt++;
            if (m_cnt == 18) m_full = 1'b1;
        end
    endtask

    task automatic push(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        check_all();
        in_valid = 1'b0;
    endtask

    task automatic accept_pair();
        mat_ready = 1'b1;
        step();
        check_all();
        mat_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_rdy_and_vld", {71'd0, in_ready && mat_valid}, 72'd0);
            chk("inv_cnt_max",     {71'd0, load_cnt <= 5'd18},     72'd1);
        end
    end

    initial begin
        int accepts;
        int cyc;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        mat_ready = 1'b0;
        flush1    = 1'b0;
        in_data1  = 8'h00;
        in_valid1 = 1'b0;
        mat_ready1 = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        check_all();

        // N=1 build: one element per matrix.
        in_valid1 = 1'b1;
        in_data1  = 8'h05;
        step();
        chk("n1_valid_after_a", {71'd0, mat_valid1}, 72'd0);
        chk("n1_cnt_after_a",   {70'd0, load_cnt1},  72'd1);
        in_data1 = 8'h07;
        step();
        in_valid1 = 1'b0;
        chk("n1_valid_full", {71'd0, mat_valid1}, 72'd1);
        chk("n1_ready_full", {71'd0, in_ready1},  72'd0);
        chk("n1_mat_a",      {64'd0, mat_a1[0][0]}, 72'h05);
        chk("n1_mat_b",      {64'd0, mat_b1[0][0]}, 72'h07);
        chk("n1_cnt_full",   {70'd0, load_cnt1},  72'd2);
        mat_ready1 = 1'b1;
        step();
        mat_ready1 = 1'b0;
        chk("n1_valid_accept", {71'd0, mat_valid1}, 72'd0);
        chk("n1_cnt_accept",   {70'd0, load_cnt1},  72'd0);

        // Stream 1..18 back to back.
        in_valid = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            in_data = 8'(i);
            step();
            check_all();
        end
        in_valid = 1'b0;
        chk("seq_valid",  {71'd0, mat_valid},  72'd1);
        chk("seq_cnt",    {67'd0, load_cnt},   72'd18);
        chk("seq_a22",    {64'd0, mat_a[2][2]}, 72'd9);
        chk("seq_b00",    {64'd0, mat_b[0][0]}, 72'd10);
        chk("seq_b22",    {64'd0, mat_b[2][2]}, 72'd18);

        // Hold in FULL with in_valid pushing 8'hFF.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all();
        end
        in_valid = 1'b0;
        accept_pair();
        chk("accept_cnt", {67'd0, load_cnt}, 72'd0);

        // Random gaps, random mat_ready, until two pairs are accepted.
        accepts = 0;
        cyc     = 0;
        while (accepts < 2 && cyc < 600) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            mat_ready = 1'($urandom_range(0, 1));
            if (m_full && mat_ready) accepts++;
            step();
            check_all();
            cyc++;
        end
        in_valid  = 1'b0;
        mat_ready = 1'b0;
        chk("rand_two_loads", 72'(accepts), 72'd2);

        // Flush after 7 transfers, coincident with an 8'hAA transfer.
        for (int i = 0; i < 7; i++) push(8'(50 + i));
        in_valid = 1'b1;
        in_data  = 8'hAA;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_all();
        chk("flush_cnt", {67'd0, load_cnt}, 72'd0);
        for (int i = 0; i < 18; i++) push(8'(100 + i));
        chk("flush_a00", {64'd0, mat_a[0][0]}, 72'd100);
        chk("flush_b22", {64'd0, mat_b[2][2]}, 72'd117);
        accept_pair();

        // Asynchronous reset between edges, mid LOAD_B.
        for (int i = 0; i < 12; i++) push(8'($urandom_range(1, 255)));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) push(8'($urandom_range(1, 255)));
        chk("recov_valid", {71'd0, mat_valid}, 72'd1);
        accept_pair();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Upstream feeder for the matrix addition stage.
- Accepts a byte stream of 2*N*N elements over a valid/ready handshake, in row-major order: matrix A first, then matrix B.
- Holds both matrices in registers and presents them as N×N 8-bit arrays with a valid flag until the consumer accepts them.
- Decouples serial input (host/UART side) from the combinational array datapath.

Parameters:
- N, 3, matrix dimension (N×N); legal range 1..16.
- DATA_W, 8, element width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; discards partial or complete load.
- in_data  input  DATA_W  stream element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept an element this cycle.
- mat_a  output  [DATA_W-1:0] x [N-1:0][N-1:0]  assembled matrix A (unpacked 2-D array).
- mat_b  output  [DATA_W-1:0] x [N-1:0][N-1:0]  assembled matrix B.
- mat_valid  output  1  mat_a/mat_b complete and stable.
- mat_ready  input  1  consumer accepts the matrix pair.
- load_cnt  output  $clog2(2*N*N+1)  elements accepted in the current load, 0..2*N*N.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD_A; row=col=0; load_cnt=0.
  - All mat_a/mat_b elements = 0; mat_valid=0; in_ready=1 once reset releases.
- Transfer: occurs on a rising edge when in_valid && in_ready.
  - in_ready is a combinational decode of state only: 1 in LOAD_A and LOAD_B, 0 in FULL.
  - It never depends on in_valid.
- States:
  - LOAD_A: each transfer writes in_data to mat_a[row][col].
    - col increments; on col==N-1, col wraps to 0 and row increments.
    - Transfer at row==N-1 && col==N-1: row=col=0, next state LOAD_B.
  - LOAD_B: same indexing into mat_b. Last-element transfer moves to FULL.
  - FULL: mat_valid=1, in_ready=0, in_data ignored.
    - mat_ready=1: next state LOAD_A, mat_valid=0 from the next cycle, load_cnt cleared to 0.
    - mat_a/mat_b retain their contents until overwritten element by element. They are not cleared on accept.
- Latency:
  - mat_valid rises the cycle after the 2*N*N-th transfer edge; minimum 2*N*N+1 cycles from the first transfer.
  - Throughput is one element per cycle. There is one bubble cycle minimum per matrix pair: the accept cycle, where in_ready=0.
- load_cnt: increments by 1 on each transfer; equals 2*N*N in FULL.
- mat_valid/mat_a/mat_b are registered outputs. Nothing combinational runs from in_data to the outputs.
- Array writes are non-arithmetic; no width conversion. Index counters are $clog2(N) bits, minimum 1 bit.
- N=1: LOAD_A and LOAD_B each take exactly one transfer.
- Boundary and simultaneous events:
  - flush=1 in any state: next state LOAD_A, row=col=0, load_cnt=0, mat_valid=0. Matrix contents are not cleared.
  - flush overrides a coincident transfer (element dropped) and a coincident mat_ready.
  - mat_ready asserted outside FULL: ignored.
  - in_valid held high during FULL: no transfer, no counter change.
  - rst_n asserted mid-load: immediate return to reset values, including clearing the matrices.
- Assertions for verification:
  - mat_valid implies state==FULL.
  - in_ready && mat_valid never both 1.
  - load_cnt <= 2*N*N.

Decomposition:
- Shared package matrix_pkg:
  - DATA_W default.
  - typedef enum state_t {LOAD_A, LOAD_B, FULL}.
  - Function clog2_min1 for index widths.
- One natural sub-module: matrix_index_counter (row/col counter with enable, synchronous clear, and a last flag at row==N-1 && col==N-1).
  - Instantiated once; its last flag drives the state transitions.

Test Plan:
- Reset then stream 1..18 (N=3) with in_valid constant:
  - mat_a = [[1,2,3],[4,5,6],[7,8,9]] and mat_b = [[10,11,12],[13,14,15],[16,17,18]].
  - mat_valid=1 exactly one cycle after the 18th transfer; load_cnt=18.
- Hold mat_ready=0 for 5 cycles in FULL while driving in_valid=1, in_data=8'hFF:
  - in_ready=0, outputs unchanged.
  - mat_ready=1 → mat_valid=0 next cycle, in_ready=1, load_cnt=0.
- Random in_valid gaps (≈50% duty) over two back-to-back loads: both pairs captured correctly; no element lost or duplicated.
- flush after 7 transfers, coincident with an in_valid transfer of value 8'hAA:
  - load_cnt=0, state LOAD_A.
  - Next 18 elements fill from mat_a[0][0]; 8'hAA does not appear.
- Assert rst_n=0 asynchronously mid-LOAD_B (between edges):
  - All outputs go to zero immediately without waiting for a clock edge.
  - Recovery load of 18 elements is correct.
- N=1 build: stream 8'h05, 8'h07 → mat_a[0][0]=5, mat_b[0][0]=7, mat_valid=1 on the 3rd edge.
